// File: rtl/servo_ramp_seq_if.sv
// Command handshake plus PWM-peripheral write port for the servo ramp sequencer.
interface servo_ramp_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_ch;
  logic [31:0] cmd_target;
  logic [15:0] cmd_step;
  logic [15:0] cmd_interval;
  logic        busy;
  logic        done;
  logic        bus_cs;
  logic        bus_wr;
  logic        bus_rd;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;

  // Sequencer side: takes commands, masters the peripheral bus
  modport master (
    input  cmd_valid, cmd_ch, cmd_target, cmd_step, cmd_interval,
    output cmd_ready, busy, done, bus_cs, bus_wr, bus_rd, bus_addr, bus_wdata
  );

  // Environment side: issues commands, observes bus and status
  modport slave (
    output cmd_valid, cmd_ch, cmd_target, cmd_step, cmd_interval,
    input  cmd_ready, busy, done, bus_cs, bus_wr, bus_rd, bus_addr, bus_wdata
  );
endinterface

// File: rtl/servo_ramp_seq.sv
// Servo ramp sequencer: initialises the 8-channel PWM peripheral, then slews
// one channel's duty register toward a target in fixed steps per command.
module servo_ramp_seq #(
  parameter int unsigned PERIOD       = 1000000,
  parameter int unsigned DEFAULT_DUTY = 75000,
  parameter int unsigned NCH          = 8
) (
  input  logic             clk,
  input  logic             rst,
  servo_ramp_seq_if.master bus_if
);

  localparam int unsigned CH_W   = 3;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WAIT, ST_WRITE} state_t;

  state_t              r_state, w_state_nx;
  logic [CH_W-1:0]     r_init_ch, w_init_ch_nx;
  logic [1:0]          r_init_sub, w_init_sub_nx;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
  logic [CNT_W-1:0]    r_intv, w_intv_nx;
  logic [CNT_W-1:0]    r_step, w_step_nx;
  logic [CH_W-1:0]     r_ch, w_ch_nx;
  logic [DATA_W-1:0]   r_target, w_target_nx;
  logic [DATA_W-1:0]   r_cur [NCH];
  logic                r_cs, w_cs_nx;
  logic [ADDR_W-1:0]   r_addr, w_addr_nx;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nx;
  logic                r_done, w_done_nx;
  logic                r_ready, w_ready_nx;
  logic                r_busy, w_busy_nx;
  logic                w_cur_we;
  logic [DATA_W-1:0]   w_cur_sel;
  logic [DATA_W-1:0]   w_step32;
  logic [DATA_W-1:0]   w_next_duty;
  logic [CNT_W-1:0]    w_intv_eff;
  logic [ADDR_W-1:0]   w_init_addr;
  logic [DATA_W-1:0]   w_init_data;

  // Byte address of a channel's register block (12 bytes per channel)
  function automatic logic [ADDR_W-1:0] ch_base(input logic [CH_W-1:0] ch);
    return (ADDR_W'(ch) << 3) + (ADDR_W'(ch) << 2);
  endfunction

  assign w_cur_sel  = r_cur[r_ch];
  assign w_step32   = DATA_W'(r_step);
  assign w_intv_eff = (bus_if.cmd_interval == '0) ? CNT_W'(1) : bus_if.cmd_interval;

  // Next duty value: compare first so the step never wraps past the target
  always_comb begin
    w_next_duty = r_target;
    if (r_step != '0) begin
      if (w_cur_sel < r_target) begin
        if ((r_target - w_cur_sel) > w_step32) w_next_duty = w_cur_sel + w_step32;
      end else if (w_cur_sel > r_target) begin
        if ((w_cur_sel - r_target) > w_step32) w_next_duty = w_cur_sel - w_step32;
      end
    end
  end

  // Init write table: per channel T, then D, then E
  always_comb begin
    w_init_addr = ch_base(r_init_ch);
    w_init_data = DATA_W'(1);
    case (r_init_sub)
      2'd0: begin
        w_init_addr = ch_base(r_init_ch) + ADDR_W'(4);
        w_init_data = DATA_W'(PERIOD);
      end
      2'd1: begin
        w_init_addr = ch_base(r_init_ch) + ADDR_W'(8);
        w_init_data = DATA_W'(DEFAULT_DUTY);
      end
      default: ;
    endcase
  end

  // Next-state and next-output logic; outputs describe the following cycle
  always_comb begin
    w_state_nx    = r_state;
    w_init_ch_nx  = r_init_ch;
    w_init_sub_nx = r_init_sub;
    w_cnt_nx      = r_cnt;
    w_intv_nx     = r_intv;
    w_step_nx     = r_step;
    w_ch_nx       = r_ch;
    w_target_nx   = r_target;
    w_cs_nx       = 1'b0;
    w_addr_nx     = '0;
    w_wdata_nx    = '0;
    w_done_nx     = 1'b0;
    w_ready_nx    = 1'b0;
    w_busy_nx     = 1'b1;
    w_cur_we      = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_cs_nx    = 1'b1;
        w_addr_nx  = w_init_addr;
        w_wdata_nx = w_init_data;
        if (r_init_sub == 2'd2) begin
          w_init_sub_nx = 2'd0;
          if (r_init_ch == CH_W'(NCH - 1)) begin
            w_init_ch_nx = '0;
            w_state_nx   = ST_IDLE;
          end else begin
            w_init_ch_nx = r_init_ch + CH_W'(1);
          end
        end else begin
          w_init_sub_nx = r_init_sub + 2'd1;
        end
      end
      ST_IDLE: begin
        w_ready_nx = 1'b1;
        w_busy_nx  = 1'b0;
        if (bus_if.cmd_valid && r_ready) begin
          w_ready_nx  = 1'b0;
          w_busy_nx   = 1'b1;
          w_ch_nx     = bus_if.cmd_ch;
          w_target_nx = bus_if.cmd_target;
          w_step_nx   = bus_if.cmd_step;
          w_intv_nx   = w_intv_eff;
          w_cnt_nx    = w_intv_eff - CNT_W'(1);
          w_state_nx  = (w_intv_eff == CNT_W'(1)) ? ST_WRITE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == CNT_W'(1)) w_state_nx = ST_WRITE;
        else                    w_cnt_nx   = r_cnt - CNT_W'(1);
      end
      ST_WRITE: begin
        w_cs_nx    = 1'b1;
        w_addr_nx  = ch_base(r_ch) + ADDR_W'(8);
        w_wdata_nx = w_next_duty;
        w_cur_we   = 1'b1;
        if (w_next_duty == r_target) begin
          w_done_nx  = 1'b1;
          w_state_nx = ST_IDLE;
        end else begin
          w_cnt_nx   = r_intv - CNT_W'(1);
          w_state_nx = (r_intv == CNT_W'(1)) ? ST_WRITE : ST_WAIT;
        end
      end
      default: w_state_nx = ST_INIT;
    endcase
  end

  // State, command latch and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_init_ch  <= '0;
      r_init_sub <= '0;
      r_cnt      <= '0;
      r_intv     <= '0;
      r_step     <= '0;
      r_ch       <= '0;
      r_target   <= '0;
      r_cs       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      r_state    <= w_state_nx;
      r_init_ch  <= w_init_ch_nx;
      r_init_sub <= w_init_sub_nx;
      r_cnt      <= w_cnt_nx;
      r_intv     <= w_intv_nx;
      r_step     <= w_step_nx;
      r_ch       <= w_ch_nx;
      r_target   <= w_target_nx;
      r_cs       <= w_cs_nx;
      r_addr     <= w_addr_nx;
      r_wdata    <= w_wdata_nx;
      r_done     <= w_done_nx;
      r_ready    <= w_ready_nx;
      r_busy     <= w_busy_nx;
    end
  end

  // Shadow copy of every channel's duty register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) r_cur[i] <= DATA_W'(DEFAULT_DUTY);
    end else if (w_cur_we) begin
      r_cur[r_ch] <= w_next_duty;
    end
  end

  assign bus_if.cmd_ready = r_ready;
  assign bus_if.busy      = r_busy;
  assign bus_if.done      = r_done;
  assign bus_if.bus_cs    = r_cs;
  assign bus_if.bus_wr    = r_cs;
  assign bus_if.bus_rd    = 1'b0;
  assign bus_if.bus_addr  = r_addr;
  assign bus_if.bus_wdata = r_wdata;

endmodule

// File: tb/tb_servo_ramp_seq.sv
// Scoreboard bench for servo_ramp_seq: stimulus pushes expected bus writes,
// a negedge monitor pops and compares every observed bus cycle.
module tb_servo_ramp_seq;

  localparam int unsigned PERIOD = 1000000;
  localparam int unsigned DEF    = 75000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  servo_ramp_seq_if u_if();

  servo_ramp_seq #(.PERIOD(PERIOD), .DEFAULT_DUTY(DEF), .NCH(8)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (u_if)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic        done;
    longint      cyc;
  } exp_t;

  exp_t   q[$];
  exp_t   mon_e;
  longint cyc = 0;
  int     errors = 0;
  int     checks = 0;
  int     nwr = 0;
  logic   chk_ready = 1'b0;
  longint model [8];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle is either an expected write or a fully idle bus
  always @(negedge clk) begin
    if (u_if.bus_cs === 1'b1) begin
      nwr++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write cyc=%0d addr=%h data=%0d", cyc, u_if.bus_addr, u_if.bus_wdata);
      end else begin
        mon_e = q.pop_front();
        if (u_if.bus_addr !== mon_e.addr || u_if.bus_wdata !== mon_e.data || u_if.done !== mon_e.done ||
            cyc != mon_e.cyc || u_if.bus_wr !== 1'b1 || u_if.bus_rd !== 1'b0 ||
            u_if.busy !== 1'b1 || u_if.cmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL bus_write got addr=%h data=%0d done=%b cyc=%0d wr=%b busy=%b rdy=%b exp addr=%h data=%0d done=%b cyc=%0d",
                   u_if.bus_addr, u_if.bus_wdata, u_if.done, cyc, u_if.bus_wr, u_if.busy, u_if.cmd_ready,
                   mon_e.addr, mon_e.data, mon_e.done, mon_e.cyc);
        end
      end
    end else begin
      checks++;
      if (u_if.bus_wr !== 1'b0 || u_if.bus_rd !== 1'b0 || u_if.bus_addr !== 8'h00 ||
          u_if.bus_wdata !== 32'h0 || u_if.done !== 1'b0) begin
        errors++;
        $display("FAIL bus_idle cyc=%0d got wr=%b rd=%b addr=%h data=%0d done=%b exp all zero",
                 cyc, u_if.bus_wr, u_if.bus_rd, u_if.bus_addr, u_if.bus_wdata, u_if.done);
      end
    end
    if (rst === 1'b0) begin
      if (chk_ready) begin
        checks++;
        if (u_if.cmd_ready !== 1'b1 || u_if.busy !== 1'b0) begin
          errors++;
          $display("FAIL ready_after_done cyc=%0d got rdy=%b busy=%b exp rdy=1 busy=0", cyc, u_if.cmd_ready, u_if.busy);
        end
      end
      chk_ready = (u_if.bus_cs === 1'b1 && u_if.done === 1'b1);
    end else begin
      chk_ready = 1'b0;
    end
  end

  // Watchdog so the bench always ends
  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d pending=%0d", cyc, q.size());
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input int addr, input longint data, input logic dn, input longint c);
    exp_t e;
    e.addr = 8'(addr);
    e.data = 32'(data);
    e.done = dn;
    e.cyc  = c;
    q.push_back(e);
  endtask

  // Init expectation: write k lands on cycle rel+1+k
  task automatic push_init(input longint rel);
    int k = 0;
    for (int ch = 0; ch < 8; ch++) begin
      push_exp(12 * ch + 4, longint'(PERIOD), 1'b0, rel + 1 + k); k++;
      push_exp(12 * ch + 8, longint'(DEF), 1'b0, rel + 1 + k);    k++;
      push_exp(12 * ch, 1, 1'b0, rel + 1 + k);                    k++;
    end
  endtask

  task automatic do_reset(input int ncyc);
    longint rel;
    @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    for (int i = 0; i < 8; i++) model[i] = longint'(DEF);
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
    checks++;
    if (u_if.bus_cs !== 1'b0 || u_if.done !== 1'b0 || u_if.cmd_ready !== 1'b0 || u_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got cs=%b done=%b rdy=%b busy=%b exp 0 0 0 1", u_if.bus_cs, u_if.done, u_if.cmd_ready, u_if.busy);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    rel = cyc;
    push_init(rel);
    while (cyc < rel + 24) @(negedge clk);
    checks++;
    if (u_if.cmd_ready !== 1'b0 || u_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL init_last_write_status got rdy=%b busy=%b exp rdy=0 busy=1", u_if.cmd_ready, u_if.busy);
    end
    @(negedge clk);
    checks++;
    if (u_if.cmd_ready !== 1'b1 || u_if.busy !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL init_ready got rdy=%b busy=%b pending=%0d exp rdy=1 busy=0 pending=0", u_if.cmd_ready, u_if.busy, q.size());
    end
  endtask

  // Offers a command (called at a negedge), returns the acceptance posedge number
  task automatic issue_cmd(input int ch, input longint tgt, input int step, input int intv, output longint n);
    int     b = 0;
    longint c, nx, ieff;
    int     k = 0;
    u_if.cmd_valid    = 1'b1;
    u_if.cmd_ch       = 3'(ch);
    u_if.cmd_target   = 32'(tgt);
    u_if.cmd_step     = 16'(step);
    u_if.cmd_interval = 16'(intv);
    while (u_if.cmd_ready !== 1'b1 && b < 5000) begin
      @(negedge clk);
      b++;
    end
    if (u_if.cmd_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept_timeout ch=%0d got rdy=%b exp rdy=1", ch, u_if.cmd_ready);
      u_if.cmd_valid = 1'b0;
      n = -1;
      return;
    end
    n    = cyc + 1;
    ieff = (intv == 0) ? 1 : longint'(intv);
    c    = model[ch];
    do begin
      k++;
      if (step == 0 || c == tgt) nx = tgt;
      else if (c < tgt)          nx = (c + step < tgt) ? c + step : tgt;
      else                       nx = (c - step > tgt) ? c - step : tgt;
      push_exp(12 * ch + 8, nx, (nx == tgt), n + k * ieff);
      c = nx;
    end while (c != tgt);
    model[ch] = tgt;
    @(negedge clk);
    u_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int b = 0;
    while (q.size() != 0 && b < 20000) begin
      @(negedge clk);
      b++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got pending=%0d exp 0", q.size());
      q.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    longint n, n2, last_a;
    int     w0, b;
    u_if.cmd_valid    = 1'b0;
    u_if.cmd_ch       = '0;
    u_if.cmd_target   = '0;
    u_if.cmd_step     = '0;
    u_if.cmd_interval = '0;

    do_reset(3);

    // Up-ramp, with a rejected command pulsed while busy
    issue_cmd(2, 75300, 100, 4, n);
    u_if.cmd_valid  = 1'b1;
    u_if.cmd_ch     = 3'd1;
    u_if.cmd_target = 32'd1;
    u_if.cmd_step   = 16'd0;
    checks++;
    if (u_if.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_reject got rdy=%b exp 0", u_if.cmd_ready);
    end
    @(negedge clk);
    u_if.cmd_valid = 1'b0;
    wait_drain();

    // Clamped down-ramp with interval 0
    issue_cmd(0, 74950, 30, 0, n);
    wait_drain();

    // Jump, then the same command again as a no-op write
    issue_cmd(7, 50000, 0, 3, n);
    wait_drain();
    issue_cmd(7, 50000, 0, 3, n);
    wait_drain();

    // Command held valid across done is taken on the first ready cycle
    issue_cmd(5, 75050, 25, 2, n);
    last_a = q[q.size() - 1].cyc;
    issue_cmd(6, 74900, 50, 1, n2);
    checks++;
    if (n2 != last_a + 2) begin
      errors++;
      $display("FAIL back_to_back_accept got edge=%0d exp %0d", n2, last_a + 2);
    end
    wait_drain();

    // Extremes of the unsigned range: no wrap on either side
    issue_cmd(4, 64'hFFFF_FF00, 0, 1, n);
    issue_cmd(4, 64'hFFFF_FFFF, 200, 1, n);
    wait_drain();
    issue_cmd(4, 100, 0, 2, n);
    issue_cmd(4, 0, 300, 1, n);
    wait_drain();

    // Reset in the middle of a ramp, then ramp the same channel from default
    issue_cmd(3, 76000, 10, 5, n);
    w0 = nwr;
    b  = 0;
    while (nwr == w0 && b < 100) begin
      @(negedge clk);
      b++;
    end
    checks++;
    if (nwr == w0) begin
      errors++;
      $display("FAIL midramp_first_write got writes=%0d exp >%0d", nwr, w0);
    end
    do_reset(3);
    issue_cmd(3, 75020, 10, 2, n);
    wait_drain();

    // Randomized commands against the model
    for (int i = 0; i < 20; i++) begin
      int ch, st, iv;
      longint tg;
      ch = int'($urandom_range(0, 7));
      tg = longint'($urandom_range(74000, 76000));
      st = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(50, 400));
      iv = int'($urandom_range(0, 4));
      issue_cmd(ch, tg, st, iv, n);
      if ($urandom_range(0, 1) == 1) wait_drain();
    end
    wait_drain();

    repeat (5) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL final_queue got pending=%0d exp 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/servo_ramp_seq.md
Name: servo_ramp_seq

Overview:
- Bus master sitting directly upstream of the 8-channel PWM register peripheral; drives its cs/addr/wr/rd/d_in write port.
- After reset, initialises all 8 channels: period T, default duty D, enable E.
- It then accepts one ramp command at a time.
- Each command slews one channel's duty register toward a target in fixed steps, at a programmable tick interval.
- Intended to move the cube-robot servos smoothly instead of jumping the pulse width.

Parameters:
- PERIOD, 1000000, value written to every T register at init (20 ms at 50 MHz).
- DEFAULT_DUTY, 75000, initial D value for every channel and reset value of the shadow duty table (1.5 ms).
- NCH, 8, number of channels; fixed at 8 by the peripheral address map.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on a posedge with cmd_valid&cmd_ready.
- cmd_ch  in  3  target channel.
- cmd_target  in  32  final duty value.
- cmd_step  in  16  duty increment per write; 0 means jump directly to target.
- cmd_interval  in  16  clk cycles between writes; 0 is treated as 1.
- busy  out  1  high in INIT, WAIT and WRITE.
- done  out  1  one-cycle pulse, coincident with the final write of a command.
- bus_cs  out  1  peripheral chip select.
- bus_wr  out  1  peripheral write strobe.
- bus_rd  out  1  peripheral read strobe; constant 0.
- bus_addr  out  8  peripheral byte address.
- bus_wdata  out  32  write data, connected to peripheral d_in.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Register and output timing:
  - All outputs are registered.
  - A bus write is a single clk cycle with bus_cs=bus_wr=1 and addr/data stable for that whole cycle. The peripheral captures on the falling edge inside that cycle.
  - Outside a write, bus_cs=bus_wr=0, bus_addr=0 and bus_wdata=0.
- Address map per channel ch:
  - E at 12*ch; data 1 = enabled.
  - T at 12*ch+4.
  - D at 12*ch+8.
- Reset behaviour:
  - Bus outputs, done and cmd_ready are 0; busy is 1.
  - Shadow duty table cur[0..7] is loaded with DEFAULT_DUTY.
  - The FSM goes to INIT with write index 0.
- States:
  - INIT:
    - 24 back-to-back write cycles, starting the first cycle after rst deasserts.
    - Order is ch0..ch7; within each channel T=PERIOD, then D=DEFAULT_DUTY, then E=1.
    - After the write to 0x54, go to IDLE; cmd_ready is 1 the following cycle.
  - IDLE:
    - cmd_ready=1, busy=0.
    - On acceptance, latch ch, target, step and I = max(cmd_interval,1); load the interval counter with I; go to WAIT.
  - WAIT:
    - Count down; after exactly I cycles, go to WRITE.
    - The first write occurs I cycles after the acceptance edge; successive writes are spaced exactly I cycles apart.
  - WRITE (one cycle):
    - If cur<target: next = min(cur+step, target).
    - If cur>target: next = max(cur-step, target).
    - If step=0 or cur=target: next = target.
    - Arithmetic is unsigned 32-bit. Compare before add/subtract so there is no overflow or underflow wrap.
    - Drive the write to 12*ch+8 with data next, and update cur[ch]=next.
    - If next==target: pulse done and go to IDLE. Otherwise reload the counter with I and go to WAIT.
- Boundary conditions:
  - A command whose target equals the current duty still produces exactly one write (same value) plus done.
  - cmd_valid outside IDLE is ignored (not queued); cmd_ready stays 0.
  - cmd_valid held high across done: the next command is accepted on the first IDLE cycle.
  - rst asserted mid-ramp or mid-INIT: everything aborts at the next posedge; the table returns to DEFAULT_DUTY and INIT restarts from index 0.
  - Shadow table values persist across commands; no bus reads are ever issued.

Test Plan:
- Init sequence: release rst → 24 consecutive write cycles with addr/data 0x04/1000000, 0x08/75000, 0x00/1, ... ending 0x54/1; cmd_ready=1 on the 25th cycle; no other bus activity.
- Up-ramp: ch=2, target=75300, step=100, interval=4, accepted at cycle N → writes to 0x20 with data 75100 at N+4, 75200 at N+8, 75300 at N+12; done only at N+12; cmd_ready=1 at N+13.
- Clamped down-ramp: ch=0, target=74950, step=30, interval=0 → writes to 0x08 with data 74970 at N+1, 74950 at N+2 with done; no value below 74950 ever appears.
- Jump and no-op:
  - ch=7, step=0, target=50000, interval=3 → single write 0x5C/50000 at N+3 with done.
  - Repeat the same command → one write 0x5C/50000 plus done.
- Busy rejection: second cmd_valid (ch=1) pulsed during the ramp above → ignored, no write to 0x14, cmd_ready stays 0 until the ramp finishes.
- Reset mid-ramp: assert rst between writes of a ch=3 ramp → bus idle during rst, INIT replays all 24 writes, then a ch=3 ramp starts from 75000.
